// File: rtl/gpio_output_stage_if.sv
// Command/pulse request bus and pad-side outputs of the GPIO output stage.
interface gpio_output_stage_if #(
    parameter int CntWidth = 16
);
    logic                cmd_valid;
    logic [1:0]          cmd;
    logic                data;
    logic                pulse_start;
    logic [CntWidth-1:0] pulse_len;
    logic                open_drain;
    logic                oe_en;
    logic                serial;
    logic                oe;
    logic                busy;

    modport master (
        output cmd_valid, cmd, data,
        output pulse_start, pulse_len,
        output open_drain, oe_en,
        input  serial, oe, busy
    );

    modport slave (
        input  cmd_valid, cmd, data,
        input  pulse_start, pulse_len,
        input  open_drain, oe_en,
        output serial, oe, busy
    );
endinterface

// File: rtl/gpio_output_stage.sv
// Per-pin GPIO output driver: level commands, one-shot pulse, pad mapping.
// Define GPIO_OUT_PULSE_EN to build the pulse FSM, counter and busy output.
module gpio_output_stage #(
    parameter int   CntWidth   = 16,
    parameter logic ResetLevel = 1'b0
) (
    input logic clk_i,
    input logic rst_ni,
    input logic en_i,
    gpio_output_stage_if.slave bus
);
    localparam logic [1:0] CmdWrite  = 2'b00;
    localparam logic [1:0] CmdSet    = 2'b01;
    localparam logic [1:0] CmdClear  = 2'b10;
    localparam logic [1:0] CmdToggle = 2'b11;

    logic level_q;
    logic level_d;
    logic serial_q;
    logic oe_q;
    logic busy_q;
    logic busy_d;

    function automatic logic apply_cmd(logic cur);
        logic res;
        res = cur;
        if (bus.cmd_valid) begin
            unique case (bus.cmd)
                CmdWrite:  res = bus.data;
                CmdSet:    res = 1'b1;
                CmdClear:  res = 1'b0;
                CmdToggle: res = ~cur;
                default:   res = cur;
            endcase
        end
        return res;
    endfunction

`ifdef GPIO_OUT_PULSE_EN
    typedef enum logic {
        IDLE,
        PULSE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic                saved_q;
    logic                saved_d;
    logic                cmd_level;

    // While pulsing, commands land in saved_q and the pad level stays frozen.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        saved_d   = saved_q;
        level_d   = level_q;
        cmd_level = level_q;
        unique case (state_q)
            IDLE: begin
                cmd_level = apply_cmd(level_q);
                level_d   = cmd_level;
                if (bus.pulse_start && (bus.pulse_len != '0)) begin
                    saved_d = cmd_level;
                    level_d = ~cmd_level;
                    cnt_d   = bus.pulse_len - CntWidth'(1);
                    state_d = PULSE;
                end
            end
            PULSE: begin
                cmd_level = apply_cmd(saved_q);
                saved_d   = cmd_level;
                if (cnt_q == '0) begin
                    level_d = cmd_level;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d == PULSE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            saved_q <= ResetLevel;
        end else if (en_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            saved_q <= saved_d;
        end
    end
`else
    logic unused_pulse;

    assign unused_pulse = bus.pulse_start ^ (^bus.pulse_len);
    assign level_d      = apply_cmd(level_q);
    assign busy_d       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q  <= ResetLevel;
            serial_q <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else if (en_i) begin
            level_q  <= level_d;
            serial_q <= bus.open_drain ? 1'b0 : level_d;
            oe_q     <= bus.oe_en & (~bus.open_drain | ~level_d);
            busy_q   <= busy_d;
        end
    end

    assign bus.serial = serial_q;
    assign bus.oe     = oe_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_gpio_output_stage.sv
// Randomized and directed checks of gpio_output_stage against a pin model.
module tb_gpio_output_stage;
    localparam int   CW = 16;
    localparam logic RL = 1'b1;
`ifdef GPIO_OUT_PULSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    int   errors = 0;
    int   checks = 0;
    bit   chk_on = 1'b0;

    gpio_output_stage_if #(.CntWidth(CW)) bus ();

    gpio_output_stage #(
        .CntWidth  (CW),
        .ResetLevel(RL)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .en_i  (en),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Pin model: true level, displayed level and remaining pulse cycles.
    logic m_lvl;
    logic m_disp;
    int   m_rem;
    logic exp_serial;
    logic exp_oe;
    logic exp_busy;

    task automatic model_reset();
        m_lvl      = RL;
        m_disp     = RL;
        m_rem      = 0;
        exp_serial = 1'b0;
        exp_oe     = 1'b0;
        exp_busy   = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (en) begin
            if (bus.cmd_valid) begin
                if (bus.cmd == 2'd0) m_lvl = bus.data;
                else if (bus.cmd == 2'd1) m_lvl = 1'b1;
                else if (bus.cmd == 2'd2) m_lvl = 1'b0;
                else m_lvl = !m_lvl;
            end
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_disp = m_lvl;
            end else if (PE && bus.pulse_start && bus.pulse_len != 0) begin
                m_rem  = int'(bus.pulse_len);
                m_disp = !m_lvl;
            end else begin
                m_disp = m_lvl;
            end
            exp_serial = bus.open_drain ? 1'b0 : m_disp;
            exp_oe     = bus.oe_en && (!bus.open_drain || !m_disp);
            exp_busy   = (m_rem > 0);
        end
    endtask

    task automatic check(string name, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("serial", bus.serial, exp_serial);
            check("oe", bus.oe, exp_oe);
            check("busy", bus.busy, exp_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cmd_tick(logic [1:0] c, logic d);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.data      = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic start_pulse(int len);
        bus.pulse_start = 1'b1;
        bus.pulse_len   = CW'(len);
    endtask

    initial begin
        rst_n           = 1'b0;
        en              = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd         = 2'd0;
        bus.data        = 1'b0;
        bus.pulse_start = 1'b0;
        bus.pulse_len   = '0;
        bus.open_drain  = 1'b0;
        bus.oe_en       = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_serial", bus.serial, 1'b0);
        check("rst_oe", bus.oe, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        chk_on = 1'b1;
        rst_n  = 1'b1;
        tick();
        check("first_serial", bus.serial, 1'b1);
        check("first_oe", bus.oe, 1'b1);

        cmd_tick(2'd1, 1'b0);
        check("seq_set", bus.serial, 1'b1);
        cmd_tick(2'd2, 1'b0);
        check("seq_clear", bus.serial, 1'b0);
        cmd_tick(2'd3, 1'b0);
        check("seq_toggle", bus.serial, 1'b1);
        cmd_tick(2'd0, 1'b0);
        check("seq_write0", bus.serial, 1'b0);

        bus.open_drain = 1'b1;
        cmd_tick(2'd0, 1'b1);
        check("od_w1_serial", bus.serial, 1'b0);
        check("od_w1_oe", bus.oe, 1'b0);
        cmd_tick(2'd0, 1'b0);
        check("od_w0_serial", bus.serial, 1'b0);
        check("od_w0_oe", bus.oe, 1'b1);
        bus.open_drain = 1'b0;

        start_pulse(3);
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.pulse_start = 1'b0;
            check("p3_serial", bus.serial, PE && k < 3);
            check("p3_busy", bus.busy, PE && k < 3);
        end

        start_pulse(3);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                bus.cmd_valid   = 1'b1;
                bus.cmd         = 2'd1;
                bus.pulse_start = 1'b1;
            end
            tick();
            bus.cmd_valid   = 1'b0;
            bus.pulse_start = 1'b0;
            check("p3set_serial", bus.serial, PE ? 1'b1 : (k >= 1));
            check("p3set_busy", bus.busy, PE && k < 3);
        end

        start_pulse(0);
        tick();
        bus.pulse_start = 1'b0;
        check("p0_serial", bus.serial, 1'b1);
        check("p0_busy", bus.busy, 1'b0);

        cmd_tick(2'd2, 1'b0);
        start_pulse(3);
        for (int k = 0; k < 6; k++) begin
            en = !(k == 1 || k == 2);
            tick();
            bus.pulse_start = 1'b0;
            check("pen_serial", bus.serial, PE && k < 5);
            check("pen_busy", bus.busy, PE && k < 5);
        end
        en = 1'b1;

        start_pulse(5);
        tick();
        bus.pulse_start = 1'b0;
        tick();
        check("prst_mid_serial", bus.serial, PE);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("prst_serial", bus.serial, 1'b0);
        check("prst_oe", bus.oe, 1'b0);
        check("prst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("prst_after_serial", bus.serial, RL);
        check("prst_after_busy", bus.busy, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            en              = ($urandom_range(0, 9) != 0);
            bus.cmd_valid   = ($urandom_range(0, 2) == 0);
            bus.cmd         = 2'($urandom_range(0, 3));
            bus.data        = 1'($urandom_range(0, 1));
            bus.pulse_start = ($urandom_range(0, 5) == 0);
            bus.pulse_len   = CW'($urandom_range(0, 6));
            bus.open_drain  = ($urandom_range(0, 3) == 0);
            bus.oe_en       = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
